// File: rtl/exhaustive_sweep_checker.sv
// Exhaustive sweep checker: walks every N-bit vector, holds each for SETTLE
// cycles, then compares the DUT output with the golden model and tallies mismatches.
module exhaustive_sweep_checker #(
  parameter int unsigned N      = 4,
  parameter int unsigned SETTLE = 2,
  parameter int unsigned ERRW   = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
  input  logic            dut_y,
  input  logic            ref_y,
  output logic [N-1:0]    vec,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [ERRW-1:0] err_count,
  output logic [N-1:0]    first_err_vec,
  output logic            first_err_valid
);

  localparam int unsigned CNTW        = 8;
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(SETTLE - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_SAMPLE,
    S_DONE
  } state_t;

  state_t          state, state_nx;
  logic [CNTW-1:0] settle_cnt, settle_cnt_nx;
  logic [N-1:0]    vec_nx, first_err_vec_nx;
  logic [ERRW-1:0] err_count_nx;
  logic            first_err_valid_nx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= S_IDLE;
      settle_cnt      <= '0;
      vec             <= '0;
      err_count       <= '0;
      first_err_vec   <= '0;
      first_err_valid <= 1'b0;
    end else begin
      state           <= state_nx;
      settle_cnt      <= settle_cnt_nx;
      vec             <= vec_nx;
      err_count       <= err_count_nx;
      first_err_vec   <= first_err_vec_nx;
      first_err_valid <= first_err_valid_nx;
    end
  end

  always_comb begin
    state_nx           = state;
    settle_cnt_nx      = settle_cnt;
    vec_nx             = vec;
    err_count_nx       = err_count;
    first_err_vec_nx   = first_err_vec;
    first_err_valid_nx = first_err_valid;
    case (state)
      S_IDLE, S_DONE: begin
        // start takes priority over a simultaneous abort here
        if (start) begin
          vec_nx             = '0;
          err_count_nx       = '0;
          first_err_vec_nx   = '0;
          first_err_valid_nx = 1'b0;
          settle_cnt_nx      = '0;
          state_nx           = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (abort) begin
          state_nx = S_IDLE;
        end else begin
          settle_cnt_nx = settle_cnt + 1'b1;
          if (settle_cnt == CNT_LAST) state_nx = S_SAMPLE;
        end
      end
      S_SAMPLE: begin
        if (abort) begin
          state_nx = S_IDLE;
        end else begin
          if (dut_y != ref_y) begin
            if (err_count != '1) err_count_nx = err_count + 1'b1;
            if (!first_err_valid) begin
              first_err_vec_nx   = vec;
              first_err_valid_nx = 1'b1;
            end
          end
          if (vec == '1) begin
            state_nx = S_DONE;
          end else begin
            vec_nx        = vec + 1'b1;
            settle_cnt_nx = '0;
            state_nx      = S_SETTLE;
          end
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  assign busy = (state == S_SETTLE) || (state == S_SAMPLE);
  assign done = (state == S_DONE);
  assign pass = done && (err_count == '0);

endmodule

// File: tb/tb_exhaustive_sweep_checker.sv
// Randomized self-checking bench for exhaustive_sweep_checker; the golden model
// derives expected counts from a per-vector mismatch mask.
module tb_exhaustive_sweep_checker;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // instance A: N=4, SETTLE=2, ERRW=8
  logic        start_a = 1'b0, abort_a = 1'b0;
  logic        dut_a, ref_a;
  logic [3:0]  vec_a, fev_a;
  logic        busy_a, done_a, pass_a, fevv_a;
  logic [7:0]  err_a;
  logic [15:0] mask_a = '0;

  // instance B: N=3, SETTLE=1, ERRW=2, DUT always inverted
  logic        start_b = 1'b0, abort_b = 1'b0;
  logic        dut_b, ref_b;
  logic [2:0]  vec_b, fev_b;
  logic        busy_b, done_b, pass_b, fevv_b;
  logic [1:0]  err_b;

  assign ref_a = ~&vec_a;
  assign dut_a = ref_a ^ mask_a[vec_a];
  assign ref_b = vec_b[0];
  assign dut_b = ~ref_b;

  exhaustive_sweep_checker #(.N(4), .SETTLE(2), .ERRW(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a),
    .dut_y(dut_a), .ref_y(ref_a), .vec(vec_a), .busy(busy_a), .done(done_a),
    .pass(pass_a), .err_count(err_a), .first_err_vec(fev_a), .first_err_valid(fevv_a)
  );

  exhaustive_sweep_checker #(.N(3), .SETTLE(1), .ERRW(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b),
    .dut_y(dut_b), .ref_y(ref_b), .vec(vec_b), .busy(busy_b), .done(done_b),
    .pass(pass_b), .err_count(err_b), .first_err_vec(fev_b), .first_err_valid(fevv_b)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Mismatches among vectors 0..upto-1 (those already sampled).
  function automatic int model_errs(input logic [15:0] m, input int upto);
    int c = 0;
    for (int i = 0; i < upto; i++) if (m[i]) c++;
    return c;
  endfunction

  function automatic int model_first(input logic [15:0] m, input int upto);
    for (int i = 0; i < upto; i++) if (m[i]) return i;
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues a start on A and counts edges until done (bounded).
  task automatic run_sweep_a(input logic [15:0] m, output int edges);
    mask_a  = m;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    edges = 0;
    while (!done_a && edges < 200) begin
      tick();
      edges++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    n_cmp++; if ({busy_a, done_a, pass_a, fevv_a} !== 4'b0) begin n_err++; $display("FAIL reset_flags: got %b want 0000", {busy_a, done_a, pass_a, fevv_a}); end
    n_cmp++; if ({vec_a, err_a, fev_a} !== 16'h0) begin n_err++; $display("FAIL reset_regs: got %h want 0000", {vec_a, err_a, fev_a}); end
    n_cmp++; if ({busy_b, done_b, pass_b, fevv_b, vec_b, err_b, fev_b} !== 12'h0) begin n_err++; $display("FAIL reset_b: got %h want 000", {busy_b, done_b, pass_b, fevv_b, vec_b, err_b, fev_b}); end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_clean_sweep();
    int edges;
    run_sweep_a(16'h0000, edges);
    n_cmp++; if (edges !== 48) begin n_err++; $display("FAIL clean_edges: got %0d want 48", edges); end
    n_cmp++; if ({done_a, pass_a, busy_a, fevv_a} !== 4'b1100) begin n_err++; $display("FAIL clean_flags: got %b want 1100", {done_a, pass_a, busy_a, fevv_a}); end
    n_cmp++; if (err_a !== 8'd0) begin n_err++; $display("FAIL clean_err: got %0d want 0", err_a); end
    n_cmp++; if (vec_a !== 4'hF) begin n_err++; $display("FAIL clean_vec: got %h want f", vec_a); end
  endtask

  task automatic test_single_fault();
    int edges;
    run_sweep_a(16'h0800, edges);
    n_cmp++; if (edges !== 48) begin n_err++; $display("FAIL fault_edges: got %0d want 48", edges); end
    n_cmp++; if (err_a !== 8'd1) begin n_err++; $display("FAIL fault_err: got %0d want 1", err_a); end
    n_cmp++; if ({fevv_a, fev_a} !== 5'b1_1011) begin n_err++; $display("FAIL fault_first: got %b want 11011", {fevv_a, fev_a}); end
    n_cmp++; if ({done_a, pass_a} !== 2'b10) begin n_err++; $display("FAIL fault_pass: got %b want 10", {done_a, pass_a}); end
  endtask

  task automatic test_final_vector_fault();
    int edges;
    run_sweep_a(16'h8000, edges);
    n_cmp++; if ({edges[7:0], err_a, fevv_a, fev_a} !== {8'd48, 8'd1, 1'b1, 4'hF}) begin n_err++; $display("FAIL last_vec: got e=%0d err=%0d v=%b f=%h want 48 1 1 f", edges, err_a, fevv_a, fev_a); end
  endtask

  task automatic test_random_masks();
    int edges, exp_e, exp_f;
    logic [15:0] m;
    for (int it = 0; it < 6; it++) begin
      m = 16'($urandom) & (it[0] ? 16'($urandom) : 16'hFFFF);
      run_sweep_a(m, edges);
      exp_e = model_errs(m, 16);
      exp_f = model_first(m, 16);
      n_cmp++; if (edges !== 48 || !done_a) begin n_err++; $display("FAIL rand_done[%0d]: got edges=%0d done=%b want 48 1", it, edges, done_a); end
      n_cmp++; if (err_a !== 8'(exp_e)) begin n_err++; $display("FAIL rand_err[%0d]: got %0d want %0d", it, err_a, exp_e); end
      n_cmp++; if (fevv_a !== (exp_f >= 0) || fev_a !== ((exp_f >= 0) ? 4'(exp_f) : 4'h0)) begin n_err++; $display("FAIL rand_first[%0d]: got %b/%h want %0d", it, fevv_a, fev_a, exp_f); end
      n_cmp++; if (pass_a !== (exp_e == 0)) begin n_err++; $display("FAIL rand_pass[%0d]: got %b want %b", it, pass_a, exp_e == 0); end
    end
  endtask

  task automatic test_saturation();
    int edges;
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    edges = 0;
    while (!done_b && edges < 100) begin
      tick();
      edges++;
    end
    n_cmp++; if (edges !== 16) begin n_err++; $display("FAIL sat_edges: got %0d want 16", edges); end
    n_cmp++; if (err_b !== 2'b11) begin n_err++; $display("FAIL sat_err: got %b want 11", err_b); end
    n_cmp++; if ({fevv_b, fev_b, pass_b, vec_b} !== {1'b1, 3'b000, 1'b0, 3'b111}) begin n_err++; $display("FAIL sat_first: got v=%b f=%b p=%b vec=%b want 1 000 0 111", fevv_b, fev_b, pass_b, vec_b); end
  endtask

  task automatic test_reset_mid_sweep();
    int edges;
    mask_a  = 16'h0003;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    repeat (20) tick();
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if ({busy_a, done_a, pass_a, fevv_a, vec_a, err_a, fev_a} !== 20'h0) begin n_err++; $display("FAIL midreset_async: got %h want 00000", {busy_a, done_a, pass_a, fevv_a, vec_a, err_a, fev_a}); end
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    n_cmp++; if ({busy_a, done_a, vec_a} !== 6'h0) begin n_err++; $display("FAIL midreset_idle: got %h want 00", {busy_a, done_a, vec_a}); end
    run_sweep_a(16'h0000, edges);
    n_cmp++; if (edges !== 48 || !pass_a) begin n_err++; $display("FAIL midreset_rerun: got edges=%0d pass=%b want 48 1", edges, pass_a); end
  endtask

  task automatic test_start_ignored();
    int edges;
    logic [15:0] m;
    m = 16'($urandom);
    mask_a  = m;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    edges = 0;
    while (!done_a && edges < 200) begin
      start_a = (edges == 9);
      tick();
      edges++;
    end
    start_a = 1'b0;
    n_cmp++; if (edges !== 48) begin n_err++; $display("FAIL restart_edges: got %0d want 48", edges); end
    n_cmp++; if (err_a !== 8'(model_errs(m, 16))) begin n_err++; $display("FAIL restart_err: got %0d want %0d", err_a, model_errs(m, 16)); end
  endtask

  // Abort raised so that edge j after the start edge sees it.
  task automatic test_abort();
    int jlist[5];
    int j, v, exp_e, exp_f;
    logic [15:0] m;
    jlist = '{30, 1, 3, 47, 0};
    jlist[4] = int'($urandom_range(2, 46));
    foreach (jlist[k]) begin
      j = jlist[k];
      m = 16'($urandom);
      mask_a  = m;
      start_a = 1'b1;
      tick();
      start_a = 1'b0;
      repeat (j - 1) tick();
      abort_a = 1'b1;
      tick();
      abort_a = 1'b0;
      repeat (3) tick();
      v = (j - 1) / 3;
      exp_e = model_errs(m, v);
      exp_f = model_first(m, v);
      n_cmp++; if ({busy_a, done_a, pass_a} !== 3'b000) begin n_err++; $display("FAIL abort_flags[j=%0d]: got %b want 000", j, {busy_a, done_a, pass_a}); end
      n_cmp++; if (vec_a !== 4'(v)) begin n_err++; $display("FAIL abort_vec[j=%0d]: got %0d want %0d", j, vec_a, v); end
      n_cmp++; if (err_a !== 8'(exp_e)) begin n_err++; $display("FAIL abort_err[j=%0d]: got %0d want %0d", j, err_a, exp_e); end
      n_cmp++; if (fevv_a !== (exp_f >= 0) || fev_a !== ((exp_f >= 0) ? 4'(exp_f) : 4'h0)) begin n_err++; $display("FAIL abort_first[j=%0d]: got %b/%h want %0d", j, fevv_a, fev_a, exp_f); end
    end
  endtask

  task automatic test_back_to_back();
    int edges;
    logic [15:0] m;
    run_sweep_a(16'h0120, edges);
    n_cmp++; if (!done_a || err_a !== 8'd2) begin n_err++; $display("FAIL b2b_first: got done=%b err=%0d want 1 2", done_a, err_a); end
    m = 16'($urandom) | 16'h0010;
    mask_a  = m;
    start_a = 1'b1;
    abort_a = 1'b1;
    tick();
    start_a = 1'b0;
    abort_a = 1'b0;
    n_cmp++; if ({busy_a, done_a, fevv_a, vec_a, err_a, fev_a} !== {3'b100, 16'h0}) begin n_err++; $display("FAIL b2b_clear: got b=%b d=%b fv=%b vec=%h err=%0d f=%h want 1 0 0 0 0 0", busy_a, done_a, fevv_a, vec_a, err_a, fev_a); end
    edges = 0;
    while (!done_a && edges < 200) begin
      tick();
      edges++;
    end
    n_cmp++; if (edges !== 48 || err_a !== 8'(model_errs(m, 16)) || fev_a !== 4'(model_first(m, 16))) begin n_err++; $display("FAIL b2b_second: got e=%0d err=%0d f=%h want 48 %0d %0d", edges, err_a, fev_a, model_errs(m, 16), model_first(m, 16)); end
  endtask

  initial begin
    test_reset();
    test_clean_sweep();
    test_single_fault();
    test_final_vector_fault();
    test_random_masks();
    test_saturation();
    test_reset_mid_sweep();
    test_start_ignored();
    test_abort();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/exhaustive_sweep_checker.md
EXHAUSTIVE_SWEEP_CHECKER -- requirements
Module: exhaustive_sweep_checker

Interface
REQ-001 Parameter N, default 4: width of the input vector driven to the combinational DUT; legal range 1..16.
REQ-002 Parameter SETTLE, default 2: clock cycles each vector is held before its output is sampled; legal range 1..255.
REQ-003 Parameter ERRW, default 8: width of the mismatch counter.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  request a full sweep; sampled on the rising edge.
REQ-007 abort  input  1  terminate the current sweep early.
REQ-008 dut_y  input  1  output of the design under test.
REQ-009 ref_y  input  1  output of the golden model for the same vector.
REQ-010 vec  output  N  current input vector, driven to both the DUT and the golden model.
REQ-011 busy  output  1  high while a sweep is in progress.
REQ-012 done  output  1  high while the most recent sweep has completed without abort.
REQ-013 pass  output  1  equals done AND (err_count==0).
REQ-014 err_count  output  ERRW  number of mismatching vectors; saturates at all-ones.
REQ-015 first_err_vec  output  N  vector value at the first mismatch of the sweep.
REQ-016 first_err_valid  output  1  high once first_err_vec holds a captured value.

Function
REQ-017 The FSM states shall be IDLE, SETTLE, SAMPLE and DONE.
REQ-018 In IDLE or DONE, start=1 at an edge shall perform the following, all at that edge: vec<=0, err_count<=0, first_err_valid<=0, first_err_vec<=0, settle counter<=0, next state SETTLE.
REQ-019 In SETTLE, the settle counter shall increment each cycle; after SETTLE cycles in SETTLE, the next state shall be SAMPLE.
REQ-020 In SAMPLE, a mismatch (dut_y!=ref_y) shall increment err_count unless err_count is already all-ones (no wrap).
REQ-021 In SAMPLE, on a mismatch while first_err_valid=0, the block shall set first_err_vec<=vec and first_err_valid<=1; later mismatches shall not alter either.
REQ-022 In SAMPLE with vec != all-ones, the block shall set vec<=vec+1, clear the settle counter, and return to SETTLE.
REQ-023 In SAMPLE with vec == all-ones, the next state shall be DONE and vec shall hold all-ones (no wrap to 0).
REQ-024 Each vector shall occupy exactly SETTLE+1 cycles, so done shall rise 2^N*(SETTLE+1) edges after the start edge.
REQ-025 busy shall be 1 in SETTLE and SAMPLE, and 0 in IDLE and DONE.
REQ-026 done shall be 1 only in DONE.
REQ-027 start while busy=1 shall be ignored.
REQ-028 abort=1 in SETTLE or SAMPLE shall send the FSM to IDLE at that edge, with no further counter update; err_count, first_err_* and vec shall hold, and done shall stay 0.
REQ-029 If abort and start are both high in IDLE or DONE, start shall win and abort shall be ignored.
REQ-030 If a mismatch occurs on the final vector, it shall be counted and captured in the same edge that enters DONE.
REQ-031 All outputs shall be registered or decoded from the state register only; no combinational path from dut_y or ref_y to any output.

Reset
REQ-032 rst_n=0 shall force, asynchronously, regardless of clk: state=IDLE, vec=0, err_count=0, first_err_vec=0, first_err_valid=0, busy=0, done=0, pass=0.
REQ-033 Reset asserted mid-sweep shall discard the sweep; after release, the block shall wait in IDLE for start.

Verification
REQ-034 N=4, SETTLE=2, dut_y=ref_y=~(a&b&c&d) over vec bits -> busy for 48 cycles, then done=1, pass=1, err_count=0, first_err_valid=0, vec=4'hF.
REQ-035 N=4, SETTLE=2, dut_y=ref_y^(vec==4'b1011) -> done after 48 cycles, err_count=1, first_err_vec=4'b1011, first_err_valid=1, pass=0.
REQ-036 N=3, SETTLE=1, ERRW=2, dut_y=~ref_y -> 8 mismatches, err_count saturates at 2'b11, first_err_vec=3'b000.
REQ-037 N=4, SETTLE=2, rst_n pulsed low at cycle 20 of a sweep -> all outputs 0 immediately; a new start then runs a full 48-cycle sweep.
REQ-038 N=4, SETTLE=2: start re-pulsed at cycle 10 -> ignored, done still at cycle 48; abort at cycle 30 -> IDLE, done=0, counters held; start from DONE -> counters cleared and a new sweep begins.
